// File: rtl/dma_channel_arbiter_if.sv
// dma_channel_arbiter_if: request/grant bundle between DMA channel logic, CPU hold handshake and the arbiter
interface dma_channel_arbiter_if;
  logic [3:0] DREQ;
  logic [3:0] maskReg;
  logic       priorityType;
  logic       HLDA;
  logic       cycleDone;
  logic       TC;
  logic       HRQ;
  logic [3:0] DACK;
  logic       grantValid;
  logic [1:0] grantChannel;
  logic [7:0] priorityOrder;
  modport master (
    output DREQ, maskReg, priorityType, HLDA, cycleDone, TC,
    input  HRQ, DACK, grantValid, grantChannel, priorityOrder
  );
  modport slave (
    input  DREQ, maskReg, priorityType, HLDA, cycleDone, TC,
    output HRQ, DACK, grantValid, grantChannel, priorityOrder
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: 4-channel DREQ arbiter with HRQ/HLDA bus-hold sequencing and fixed/rotating priority
module dma_channel_arbiter #(
  parameter int         NCH           = 4,
  parameter logic [7:0] DEFAULT_ORDER = 8'b11_10_01_00
) (
  input logic CLK,
  input logic RESET,
  dma_channel_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, REQ, GRANT, RELEASE} state_t;
  state_t           state;
  logic             hrq;
  logic [NCH-1:0]   dack;
  logic             valid;
  logic [1:0]       ch;
  logic [7:0]       ord;
  logic [NCH-1:0]   eff;
  logic [1:0]       win;
  logic             to_release;
  assign eff = bus.DREQ & ~bus.maskReg;
  assign to_release = state == GRANT && (!bus.HLDA || (bus.cycleDone && (bus.TC || !eff[ch])));
  // Scan lowest to highest priority so the highest-priority requester is written last
  always_comb begin
    win = ord[1:0];
    for (int i = 3; i >= 0; i--)
      if (eff[ord[2*i +: 2]]) win = ord[2*i +: 2];
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      hrq   <= 1'b0;
      dack  <= '0;
      valid <= 1'b0;
      ch    <= 2'b00;
      ord   <= DEFAULT_ORDER;
    end else begin
      ord <= !bus.priorityType ? DEFAULT_ORDER : to_release ? {ch, ch + 2'd3, ch + 2'd2, ch + 2'd1} : ord;
      case (state)
        IDLE: if (|eff) begin
          state <= REQ;
          hrq   <= 1'b1;
        end
        REQ: if (eff == '0) begin
          state <= IDLE;
          hrq   <= 1'b0;
        end else if (bus.HLDA) begin
          state <= GRANT;
          dack  <= NCH'(1) << win;
          ch    <= win;
          valid <= 1'b1;
        end
        GRANT: if (to_release) begin
          state <= RELEASE;
          hrq   <= 1'b0;
          dack  <= '0;
          valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.HRQ           = hrq;
  assign bus.DACK          = dack;
  assign bus.grantValid    = valid;
  assign bus.grantChannel  = ch;
  assign bus.priorityOrder = ord;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter: directed scenarios plus randomized run against a behavioural arbiter model
module tb_dma_channel_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  int vectors = 0;
  int miscompares = 0;
  dma_channel_arbiter_if bus();
  dma_channel_arbiter dut (.CLK(CLK), .RESET(RESET), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle_inputs;
    bus.DREQ = 4'b0000;
    bus.maskReg = 4'b0000;
    bus.HLDA = 1'b0;
    bus.cycleDone = 1'b0;
    bus.TC = 1'b0;
  endtask
  task automatic test_reset;
    bus.priorityType = 1'b0;
    idle_inputs();
    bus.DREQ = 4'b1111;
    bus.HLDA = 1'b1;
    RESET = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.HRQ !== 1'b0) begin miscompares++; $display("FAIL reset_hrq got %b want 0", bus.HRQ); end
    vectors++;
    if (bus.DACK !== 4'b0000) begin miscompares++; $display("FAIL reset_dack got %b want 0000", bus.DACK); end
    vectors++;
    if (bus.priorityOrder !== 8'b11_10_01_00) begin miscompares++; $display("FAIL reset_order got %b want 11100100", bus.priorityOrder); end
    vectors++;
    if (bus.grantValid !== 1'b0 || bus.grantChannel !== 2'b00) begin miscompares++; $display("FAIL reset_grant got %b/%b want 0/00", bus.grantValid, bus.grantChannel); end
    RESET = 1'b0;
    idle_inputs();
    tick();
  endtask
  task automatic test_fixed;
    bus.priorityType = 1'b0;
    bus.DREQ = 4'b1110;
    tick();
    vectors++;
    if (bus.HRQ !== 1'b1) begin miscompares++; $display("FAIL fixed_hrq got %b want 1", bus.HRQ); end
    tick(); tick(); tick();
    vectors++;
    if (bus.DACK !== 4'b0000) begin miscompares++; $display("FAIL fixed_wait_dack got %b want 0000", bus.DACK); end
    bus.HLDA = 1'b1;
    tick();
    vectors++;
    if (bus.DACK !== 4'b0010 || bus.grantChannel !== 2'd1 || bus.grantValid !== 1'b1) begin
      miscompares++; $display("FAIL fixed_grant got dack=%b ch=%0d v=%b want 0010/1/1", bus.DACK, bus.grantChannel, bus.grantValid);
    end
    bus.cycleDone = 1'b1;
    bus.TC = 1'b1;
    tick();
    vectors++;
    if (bus.DACK !== 4'b0000 || bus.HRQ !== 1'b0 || bus.grantValid !== 1'b0) begin
      miscompares++; $display("FAIL fixed_release got dack=%b hrq=%b v=%b want 0000/0/0", bus.DACK, bus.HRQ, bus.grantValid);
    end
    idle_inputs();
    tick();
    vectors++;
    if (bus.priorityOrder !== 8'b11_10_01_00 || bus.HRQ !== 1'b0) begin
      miscompares++; $display("FAIL fixed_order got %b hrq=%b want 11100100/0", bus.priorityOrder, bus.HRQ);
    end
  endtask
  task automatic test_rotating;
    bus.priorityType = 1'b1;
    bus.DREQ = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      bus.HLDA = 1'b0;
      tick();
      vectors++;
      if (bus.HRQ !== 1'b1) begin miscompares++; $display("FAIL rot_hrq[%0d] got %b want 1", k, bus.HRQ); end
      bus.HLDA = 1'b1;
      tick();
      vectors++;
      if (bus.DACK !== 4'(1 << k)) begin miscompares++; $display("FAIL rot_dack[%0d] got %b want %b", k, bus.DACK, 4'(1 << k)); end
      bus.cycleDone = 1'b1;
      bus.TC = 1'b1;
      tick();
      if (k == 0) begin
        vectors++;
        if (bus.priorityOrder !== 8'b00_11_10_01) begin miscompares++; $display("FAIL rot_order got %b want 00111001", bus.priorityOrder); end
      end
      bus.cycleDone = 1'b0;
      bus.TC = 1'b0;
      bus.HLDA = 1'b0;
      tick();
      vectors++;
      if (bus.HRQ !== 1'b0) begin miscompares++; $display("FAIL rot_gap[%0d] got hrq=%b want 0", k, bus.HRQ); end
    end
    idle_inputs();
    bus.priorityType = 1'b0;
    tick();
  endtask
  task automatic test_mask_withdraw;
    bus.maskReg = 4'b0001;
    bus.DREQ = 4'b0001;
    tick(); tick(); tick();
    vectors++;
    if (bus.HRQ !== 1'b0) begin miscompares++; $display("FAIL masked_hrq got %b want 0", bus.HRQ); end
    bus.maskReg = 4'b0000;
    tick();
    vectors++;
    if (bus.HRQ !== 1'b1) begin miscompares++; $display("FAIL unmask_hrq got %b want 1", bus.HRQ); end
    bus.DREQ = 4'b0000;
    tick();
    vectors++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000) begin miscompares++; $display("FAIL withdraw got hrq=%b dack=%b want 0/0000", bus.HRQ, bus.DACK); end
    bus.HLDA = 1'b1;
    tick();
    vectors++;
    if (bus.HRQ !== 1'b0 || bus.DACK !== 4'b0000) begin miscompares++; $display("FAIL withdraw_hold got hrq=%b dack=%b want 0/0000", bus.HRQ, bus.DACK); end
    idle_inputs();
  endtask
  task automatic test_demand_abort;
    bus.DREQ = 4'b0100;
    tick();
    bus.HLDA = 1'b1;
    bus.DREQ = 4'b1100;
    tick();
    vectors++;
    if (bus.DACK !== 4'b0100) begin miscompares++; $display("FAIL demand_grant got %b want 0100", bus.DACK); end
    bus.cycleDone = 1'b1;
    bus.TC = 1'b0;
    bus.DREQ = 4'b0101;
    tick();
    vectors++;
    if (bus.DACK !== 4'b0100 || bus.grantValid !== 1'b1) begin miscompares++; $display("FAIL demand_cont got dack=%b v=%b want 0100/1", bus.DACK, bus.grantValid); end
    bus.cycleDone = 1'b0;
    bus.HLDA = 1'b0;
    tick();
    vectors++;
    if (bus.DACK !== 4'b0000 || bus.HRQ !== 1'b0) begin miscompares++; $display("FAIL abort got dack=%b hrq=%b want 0000/0", bus.DACK, bus.HRQ); end
    idle_inputs();
    tick();
    vectors++;
    if (bus.HRQ !== 1'b0 || bus.grantValid !== 1'b0) begin miscompares++; $display("FAIL abort_idle got hrq=%b v=%b want 0/0", bus.HRQ, bus.grantValid); end
  endtask
  task automatic test_mid_reset;
    bus.priorityType = 1'b1;
    bus.DREQ = 4'b0001;
    tick();
    bus.HLDA = 1'b1;
    tick();
    bus.cycleDone = 1'b1;
    bus.TC = 1'b1;
    tick();
    bus.cycleDone = 1'b0;
    bus.TC = 1'b0;
    bus.HLDA = 1'b0;
    bus.DREQ = 4'b1000;
    tick();
    tick();
    bus.HLDA = 1'b1;
    tick();
    vectors++;
    if (bus.DACK !== 4'b1000 || bus.priorityOrder !== 8'b00_11_10_01) begin
      miscompares++; $display("FAIL midrst_pre got dack=%b order=%b want 1000/00111001", bus.DACK, bus.priorityOrder);
    end
    RESET = 1'b1;
    tick();
    vectors++;
    if (bus.DACK !== 4'b0000 || bus.HRQ !== 1'b0 || bus.priorityOrder !== 8'b11_10_01_00) begin
      miscompares++; $display("FAIL midrst got dack=%b hrq=%b order=%b want 0000/0/11100100", bus.DACK, bus.HRQ, bus.priorityOrder);
    end
    RESET = 1'b0;
    bus.priorityType = 1'b0;
    idle_inputs();
    tick();
  endtask
  task automatic test_random;
    int st, hrq, valid, ch, dack, win;
    int prio[4];
    int old_prio[4];
    bit rel;
    logic [3:0] eff;
    logic [7:0] exp_ord;
    st = 0; hrq = 0; valid = 0; ch = 0; dack = 0;
    prio = '{0, 1, 2, 3};
    for (int n = 0; n < 3000; n++) begin
      RESET = ($urandom_range(0, 99) < 2);
      bus.DREQ = 4'($urandom);
      bus.maskReg = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 49) == 0) bus.priorityType = ~bus.priorityType;
      bus.HLDA = (hrq != 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
      bus.cycleDone = ($urandom_range(0, 9) < 3);
      bus.TC = 1'($urandom);
      eff = bus.DREQ & ~bus.maskReg;
      old_prio = prio;
      if (RESET) begin
        st = 0; hrq = 0; valid = 0; ch = 0; dack = 0;
        prio = '{0, 1, 2, 3};
      end else begin
        rel = (st == 2) && (!bus.HLDA || (bus.cycleDone && (bus.TC || !eff[ch])));
        if (!bus.priorityType) prio = '{0, 1, 2, 3};
        else if (rel) prio = '{(ch + 1) % 4, (ch + 2) % 4, (ch + 3) % 4, ch};
        if (st == 0) begin
          if (eff != 0) begin st = 1; hrq = 1; end
        end else if (st == 1) begin
          if (eff == 0) begin st = 0; hrq = 0; end
          else if (bus.HLDA) begin
            win = -1;
            foreach (old_prio[i]) if (win < 0 && eff[old_prio[i]]) win = old_prio[i];
            ch = win; dack = 1 << win; valid = 1; st = 2;
          end
        end else if (st == 2) begin
          if (rel) begin st = 3; hrq = 0; dack = 0; valid = 0; end
        end else st = 0;
      end
      exp_ord = {2'(prio[3]), 2'(prio[2]), 2'(prio[1]), 2'(prio[0])};
      tick();
      vectors++;
      if (bus.HRQ !== 1'(hrq) || bus.DACK !== 4'(dack) || bus.grantValid !== 1'(valid) || bus.grantChannel !== 2'(ch)) begin
        miscompares++;
        $display("FAIL rand_out[%0d] got hrq=%b dack=%b v=%b ch=%0d want %0d/%b/%0d/%0d", n, bus.HRQ, bus.DACK, bus.grantValid, bus.grantChannel, hrq, 4'(dack), valid, ch);
      end
      vectors++;
      if (bus.priorityOrder !== exp_ord || !$onehot0(bus.DACK)) begin
        miscompares++;
        $display("FAIL rand_order[%0d] got order=%b dack=%b want %b", n, bus.priorityOrder, bus.DACK, exp_ord);
      end
    end
    RESET = 1'b0;
    idle_inputs();
  endtask
  initial begin
    RESET = 1'b1;
    test_reset();
    test_fixed();
    test_rotating();
    test_mask_withdraw();
    test_demand_abort();
    test_mid_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
- Four-channel request arbiter and bus-hold sequencer for the 8237-style DMA controller.
- Samples DREQ[3:0] and applies the channel mask.
- Raises HRQ to the CPU, waits for HLDA, then grants exactly one channel by fixed or rotating priority.
- Drives DACK one-hot and the granted channel number to the timing-control block, and holds the grant until the transfer cycle completes.

Parameters:
- NCH, 4, number of channels (fixed at 4; priority field encoding depends on it)
- DEFAULT_ORDER, 8'b11_10_01_00, reset priority order: field [1:0] holds the highest-priority channel, [7:6] the lowest

Ports:
- CLK  in  1  system clock; all state updates on posedge
- RESET  in  1  synchronous, active-high reset
- DREQ  in  4  channel DMA requests, active high, level-sensitive
- maskReg  in  4  per-channel mask; 1 means the channel is ignored
- priorityType  in  1  0 = fixed priority, 1 = rotating priority (from commandReg)
- HLDA  in  1  hold acknowledge from CPU
- cycleDone  in  1  one-cycle pulse from timing control at the end of the S4 transfer cycle
- TC  in  1  terminal count of the granted channel, valid with cycleDone
- HRQ  out  1  hold request to CPU
- DACK  out  4  one-hot DMA acknowledge
- grantValid  out  1  high while in GRANT
- grantChannel  out  2  encoded granted channel
- priorityOrder  out  8  current priority order, 4 × 2-bit fields

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high, and is sampled only at posedge CLK.
- Reset values: after an edge with RESET=1, state=IDLE, HRQ=0, DACK=4'b0000, grantValid=0, grantChannel=2'b00, priorityOrder=DEFAULT_ORDER.
- Reset mid-operation: RESET overrides all other inputs, including during GRANT. DACK drops at the same edge.
- Effective request: effReq = DREQ & ~maskReg.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- IDLE:
  - HRQ=0, DACK=0.
  - If |effReq at an edge, go to REQ. HRQ is 1 after that edge, giving 1-cycle latency.
- REQ:
  - HRQ=1, DACK=0.
  - If effReq==0 at an edge (request withdrawn or masked before HLDA), go to IDLE and HRQ=0.
  - Otherwise, if HLDA=1, resolve the winner: scan priorityOrder fields from [1:0] to [7:6] and take the first channel with effReq set. Load DACK, grantChannel and grantValid=1, and go to GRANT.
  - Winner selection uses effReq sampled at the HLDA edge, not the effReq that caused entry to REQ.
- GRANT:
  - HRQ=1, DACK is held constant, grantValid=1.
  - A new, higher-priority DREQ does not preempt the grant.
  - Exit to RELEASE at an edge when any of these holds:
    - cycleDone=1 and (TC=1 or effReq[grantChannel]=0)
    - HLDA=0 (abort)
  - If cycleDone=1, TC=0 and effReq[grantChannel]=1, stay in GRANT (demand continuation) with the same channel.
- RELEASE:
  - Exactly one cycle with HRQ=0, DACK=0, grantValid=0. Then go to IDLE unconditionally, even if requests are pending.
  - This guarantees at least 2 cycles of HRQ low between grants.
- Priority update, applied on the edge entering RELEASE:
  - priorityType=1: rotate so the granted channel n becomes lowest. New order = {n, n+3, n+2, n+1} mod 4, listed field [7:6] down to [1:0].
    - Example: grant ch1 gives 8'b01_00_11_10 (ch2 highest).
  - priorityType=0: priorityOrder is forced to DEFAULT_ORDER on every edge, regardless of state.
  - Switching 1→0 restores the default on the next edge.
- Invariants:
  - DACK is $onehot0 at all times.
  - DACK!=0 implies HRQ=1 and state==GRANT.
  - grantChannel equals the encoding of DACK while grantValid=1.
  - priorityOrder fields always form a permutation of 0..3.
- Simultaneous events:
  - RESET beats everything.
  - In GRANT, HLDA=0 together with cycleDone goes to RELEASE.
  - In REQ, a DREQ change on the HLDA edge uses the new effReq.

Test Plan:
- Reset: RESET=1 for 2 cycles with DREQ=4'b1111, HLDA=1 → HRQ=0, DACK=0000, priorityOrder=8'b11_10_01_00 after the edge.
- Fixed priority: priorityType=0, DREQ=4'b1110, HLDA rises 3 cycles after HRQ → DACK=0010, grantChannel=1; cycleDone+TC → RELEASE, then priorityOrder stays 8'b11_10_01_00.
- Rotating priority: priorityType=1, DREQ=4'b1111 held, four successive grants, each ending with TC → DACK sequence 0001, 0010, 0100, 1000. After the first grant, priorityOrder=8'b00_11_10_01.
- Masking and withdrawal: maskReg=4'b0001, DREQ=4'b0001 → HRQ stays 0. Then maskReg=0, DREQ drops in REQ before HLDA → HRQ returns to 0 with no DACK.
- Demand continuation and abort: grant ch2; cycleDone with TC=0 and DREQ[2]=1 → DACK stays 0100. HLDA falls → next cycle DACK=0000, HRQ=0, then IDLE.
- Mid-grant reset: RESET=1 while DACK=1000 and priorityOrder rotated → next edge DACK=0000, HRQ=0, priorityOrder=8'b11_10_01_00.
